dio_burst_sequencer: RTL and testbench
======================================

// Module: dio_burst_sequencer
// PURPOSE
//  Downstream consumer of the clock-divider pulse. Uses the divided pulse as a single-cycle tick enable and emits
//  a triggered burst of N pulses (programmable high/low width in ticks) on a DIO output pin. A burst is started by
//  the rising edge of a DIO input trigger. Config comes from control registers; progress is reported on status registers.
// PARAMETERS
//  CNT_W   16  width of pulse-count and phase-width fields
//  OVR_W   8   width of saturating trigger-overrun counter
// PORTS
//  clk          in   1      system clock; sole clock domain
//  reset        in   1      synchronous, active-high; clears all state on the next rising edge of clk
//  tick         in   1      single-cycle enable from clock divider; all timing is counted in ticks
//  trig_in      in   1      raw DIO trigger; asynchronous to clk
//  enable       in   1      burst enable (control bit); 0 = abort/idle
//  n_pulses     in   CNT_W  pulses per burst; 0 = continuous until enable drops
//  high_ticks   in   CNT_W  pulse high width in ticks; 0 treated as 1
//  low_ticks    in   CNT_W  pulse low width in ticks; 0 treated as 1
//  pulse_out    out  1      burst output to DIO pin, registered
//  busy         out  1      1 in ARMED/HIGH/LOW
//  done         out  1      one-cycle strobe on normal burst completion
//  pulse_idx    out  CNT_W  pulses completed in current/last burst
//  overrun_cnt  out  OVR_W  triggers ignored while busy, saturating
// BEHAVIOUR
//  - Reset values: pulse_out=0, busy=0, done=0, pulse_idx=0, overrun_cnt=0, state=IDLE, sync flops=0.
//  - Trigger path: 2-FF synchronizer + rising-edge detect; edge valid 3 clk after trig_in rises.
//  - States: IDLE, ARMED, HIGH, LOW.
//   IDLE : valid edge & enable=1 -> ARMED; latch n_pulses/high_ticks/low_ticks (0->1 rule applied at latch); pulse_idx<=0.
//   ARMED: tick -> HIGH, phase_cnt<=high_ticks. No tick -> wait (aligns burst to tick grid).
//   HIGH : pulse_out=1. On tick: phase_cnt==1 -> LOW, phase_cnt<=low_ticks, pulse_idx<=pulse_idx+1; else decrement.
//   LOW  : pulse_out=0. On tick: phase_cnt==1 -> if n!=0 and pulse_idx==n: IDLE, done=1 for one cycle;
//          else HIGH, phase_cnt<=high_ticks. Else decrement.
//  - pulse_out is registered from next-state: rises the clk after the ARMED tick; high exactly high_ticks*T_tick clk.
//  - Latched config is frozen for the whole burst; register writes mid-burst take effect on next trigger.
//  - enable=0 in any busy state -> IDLE next clk, pulse_out=0, done not asserted, pulse_idx holds (abort).
//  - Valid edge while busy: ignored, overrun_cnt+1 (saturates at 2^OVR_W-1, cleared only by reset).
//  - Edge and enable=0 same cycle in IDLE: no start. Edge in same cycle as done/burst end: counted as overrun.
//  - Continuous mode (n=0): pulse_idx wraps at 2^CNT_W-1 -> 0; never asserts done.
//  - tick only sampled in ARMED/HIGH/LOW; tick held high continuously = one tick per clk (still valid).
//  - reset mid-burst: pulse_out low on the following clk, all counters cleared.
// STRUCTURE
//  - Package dio_burst_pkg: state encoding localparams (IDLE=0, ARMED=1, HIGH=2, LOW=3), CNT_W/OVR_W defaults.
//  - Sub-module trig_sync_edge: 2-FF synchronizer + edge detect, outputs 1-cycle rise strobe; reset clears to 0.
//  - Top: FSM, phase counter, pulse counter, overrun counter; status[] maps {state, busy, pulse_idx, overrun_cnt}.
// TESTING
//  1 tick every 4 clk, n=3, high=2, low=3, trig rise -> 3 pulses of 8 clk high / 12 clk low, done once, pulse_idx=3.
//  2 high=0, low=0, n=2, tick every clk -> treated as 1/1: 1-clk high, 1-clk low, 2 pulses, done once.
//  3 n=0 continuous, high=1, low=1, tick every 2 clk -> square wave period 4 clk; enable->0 mid-HIGH -> pulse_out 0 next clk, no done.
//  4 second trig edge during burst, then 300 more edges -> burst unaffected, overrun_cnt saturates at 255.
//  5 change high_ticks 2->5 mid-burst -> current burst keeps 2; next trigger uses 5.
//  6 assert reset during HIGH -> next clk pulse_out=0, busy=0, pulse_idx=0, overrun_cnt=0; trig glitch <1 clk ignored or seen once.

Source files
------------

// File: rtl/dio_burst_pkg.sv
// dio_burst_pkg: shared state encoding and default widths for the DIO burst sequencer
package dio_burst_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int OVR_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;
endpackage

// File: rtl/trig_sync_edge.sv
// trig_sync_edge: 2-FF synchronizer plus registered rising-edge strobe for an async trigger
module trig_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic trig_in,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, s3, rise} <= '0;
    end else begin
      s1 <= trig_in;
      s2 <= s1;
      s3 <= s2;
      rise <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/dio_burst_sequencer.sv
// dio_burst_sequencer: tick-timed burst of N pulses on a DIO pin, started by a trigger edge
module dio_burst_sequencer
  import dio_burst_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OVR_W = OVR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             trig_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [CNT_W-1:0] high_ticks,
  input  logic [CNT_W-1:0] low_ticks,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx,
  output logic [OVR_W-1:0] overrun_cnt
);
  state_t state;
  logic [CNT_W-1:0] n_l, h_l, l_l, phase;
  logic rise;

  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  trig_sync_edge u_sync (.clk(clk), .reset(reset), .trig_in(trig_in), .rise(rise));

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n_l <= '0;
      h_l <= '0;
      l_l <= '0;
      phase <= '0;
      pulse_out <= 1'b0;
      done <= 1'b0;
      pulse_idx <= '0;
      overrun_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (rise && busy && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
      // abort wins over any tick-driven transition in the same cycle
      if (busy && !enable) begin
        state <= IDLE;
        pulse_out <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rise && enable) begin
            state <= ARMED;
            n_l <= n_pulses;
            h_l <= nz(high_ticks);
            l_l <= nz(low_ticks);
            pulse_idx <= '0;
          end
          ARMED: if (tick) begin
            state <= HIGH;
            phase <= h_l;
            pulse_out <= 1'b1;
          end
          HIGH: if (tick) begin
            if (phase == CNT_W'(1)) begin
              state <= LOW;
              phase <= l_l;
              pulse_idx <= pulse_idx + 1'b1;
              pulse_out <= 1'b0;
            end else phase <= phase - 1'b1;
          end
          LOW: if (tick) begin
            if (phase == CNT_W'(1)) begin
              if (n_l != '0 && pulse_idx == n_l) begin
                state <= IDLE;
                done <= 1'b1;
              end else begin
                state <= HIGH;
                phase <= h_l;
                pulse_out <= 1'b1;
              end
            end else phase <= phase - 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dio_burst_sequencer.sv
// tb_dio_burst_sequencer: directed self-checking bench for dio_burst_sequencer
module tb_dio_burst_sequencer;
  logic clk = 0, reset = 1, tick = 0, trig_in = 0, enable = 0;
  logic [15:0] n_pulses = 0, high_ticks = 0, low_ticks = 0, pulse_idx;
  logic pulse_out, busy, done;
  logic [7:0] overrun_cnt;
  int tests = 0, fails = 0;
  int tdiv = 0, tcnt = 0;
  int rises, dones, run, hi_min, hi_max, lo_min, lo_max;
  logic prev;

  dio_burst_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .trig_in(trig_in), .enable(enable),
    .n_pulses(n_pulses), .high_ticks(high_ticks), .low_ticks(low_ticks),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulse_idx(pulse_idx),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    rises = 0; dones = 0; run = 0; prev = pulse_out;
    hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (pulse_out && !prev) begin
        rises++;
        if (rises > 1) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        run = 1;
      end else if (!pulse_out && prev) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        run = 1;
      end else run++;
      prev = pulse_out;
      if (tdiv == 0) tick = 0;
      else begin
        tcnt = (tcnt + 1) % tdiv;
        tick = (tcnt == 0);
      end
    end
  endtask

  task automatic trig();
    trig_in = 1;
    cyc(2);
    trig_in = 0;
    cyc(3);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (busy && k < bound) begin cyc(1); k++; end
    chk(tag, {31'd0, busy}, 0);
  endtask

  task automatic wait_hi(input string tag, input int bound);
    int k = 0;
    while (!pulse_out && k < bound) begin cyc(1); k++; end
    chk(tag, {31'd0, pulse_out}, 1);
  endtask

  initial begin
    cyc(3);
    chk("rst_pulse", {31'd0, pulse_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_idx", {16'd0, pulse_idx}, 0);
    chk("rst_ovr", {24'd0, overrun_cnt}, 0);
    reset = 0;
    cyc(2);

    // edge while disabled must not start
    clr_stats();
    trig();
    chk("dis_nostart", {31'd0, busy}, 0);

    // 1: tick/4, n=3 high=2 low=3 -> 8 clk high, 12 clk low
    enable = 1; tdiv = 4; n_pulses = 3; high_ticks = 2; low_ticks = 3;
    clr_stats();
    trig();
    chk("t1_busy", {31'd0, busy}, 1);
    wait_idle("t1_end", 300);
    chk("t1_rises", rises, 3);
    chk("t1_hi_min", hi_min, 8);
    chk("t1_hi_max", hi_max, 8);
    chk("t1_lo_min", lo_min, 12);
    chk("t1_lo_max", lo_max, 12);
    chk("t1_done", dones, 1);
    chk("t1_idx", {16'd0, pulse_idx}, 3);
    chk("t1_ovr", {24'd0, overrun_cnt}, 0);

    // 2: zero widths treated as 1, tick every clk
    tdiv = 1; n_pulses = 2; high_ticks = 0; low_ticks = 0;
    clr_stats();
    trig();
    wait_idle("t2_end", 50);
    chk("t2_rises", rises, 2);
    chk("t2_hi", hi_max, 1);
    chk("t2_lo", lo_max, 1);
    chk("t2_done", dones, 1);
    chk("t2_idx", {16'd0, pulse_idx}, 2);

    // 3: continuous square wave, then abort mid-HIGH
    tdiv = 2; n_pulses = 0; high_ticks = 1; low_ticks = 1;
    clr_stats();
    trig();
    cyc(40);
    chk("t3_busy", {31'd0, busy}, 1);
    chk("t3_hi_min", hi_min, 2);
    chk("t3_hi_max", hi_max, 2);
    chk("t3_lo", lo_max, 2);
    wait_hi("t3_wait_hi", 10);
    enable = 0;
    cyc(1);
    chk("t3_abort_pulse", {31'd0, pulse_out}, 0);
    chk("t3_abort_busy", {31'd0, busy}, 0);
    chk("t3_abort_idx", {16'd0, pulse_idx}, rises - 1);
    cyc(5);
    chk("t3_no_done", dones, 0);

    // 4: long burst, overrun edges saturate at 255
    enable = 1; tdiv = 4; n_pulses = 100; high_ticks = 2; low_ticks = 3;
    clr_stats();
    trig();
    cyc(10);
    trig();
    chk("t4_ovr1", {24'd0, overrun_cnt}, 1);
    for (int i = 0; i < 300; i++) begin
      trig_in = 1; cyc(2);
      trig_in = 0; cyc(2);
    end
    cyc(4);
    chk("t4_busy", {31'd0, busy}, 1);
    chk("t4_ovr_sat", {24'd0, overrun_cnt}, 255);
    wait_idle("t4_end", 3000);
    chk("t4_rises", rises, 100);
    chk("t4_hi", hi_max, 8);
    chk("t4_lo", lo_min, 12);
    chk("t4_done", dones, 1);
    chk("t4_idx", {16'd0, pulse_idx}, 100);

    // 5: config frozen for the running burst
    tdiv = 1; n_pulses = 2; high_ticks = 2; low_ticks = 1;
    clr_stats();
    trig();
    wait_hi("t5_wait_hi", 10);
    high_ticks = 5;
    wait_idle("t5_end1", 50);
    chk("t5_hi_min_old", hi_min, 2);
    chk("t5_hi_max_old", hi_max, 2);
    clr_stats();
    trig();
    wait_idle("t5_end2", 50);
    chk("t5_hi_new", hi_max, 5);
    chk("t5_rises", rises, 2);

    // 6: reset during HIGH, then sub-cycle glitch
    n_pulses = 0; high_ticks = 4; low_ticks = 4;
    clr_stats();
    trig();
    trig();
    chk("t6_ovr", {24'd0, overrun_cnt}, 256 == 256 ? 255 : 0);
    wait_hi("t6_wait_hi", 20);
    reset = 1;
    cyc(1);
    chk("t6_pulse", {31'd0, pulse_out}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_idx", {16'd0, pulse_idx}, 0);
    chk("t6_ovr_clr", {24'd0, overrun_cnt}, 0);
    reset = 0;
    cyc(2);
    trig_in = 1;
    #3;
    trig_in = 0;
    clr_stats();
    cyc(20);
    chk("t6_glitch_busy", {31'd0, busy}, 0);
    chk("t6_glitch_rises", rises, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
